// File: rtl/demux_rr_arbiter.sv
// demux_rr_arbiter: round-robin owner of a shared 2-to-4 active-low decoder with break-before-make gap and hold timeout
module demux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int GAP_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       en_n,
  output logic [3:0] grant_n,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);
  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic [3:0] gap_cnt;
  logic [1:0] win;
  logic       go;
  // descending scan so the requester closest after ptr is assigned last
  always_comb begin
    win = ptr;
    for (int i = 3; i >= 0; i--)
      if (req[ptr + 2'(i)]) win = ptr + 2'(i);
  end
  assign go = |req && (state == IDLE || (state == GAP && gap_cnt == GAP_LAST));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'b00;
      en_n     <= 1'b1;
      grant_n  <= 4'b1111;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gap_cnt  <= 4'd0;
    end else begin
      timeout <= 1'b0;
      if (go) begin
        state    <= GRANT;
        sel      <= win;
        en_n     <= 1'b0;
        grant_n  <= ~(4'b0001 << win);
        busy     <= 1'b1;
        hold_cnt <= 8'd0;
      end else if (state == GRANT) begin
        hold_cnt <= hold_cnt + 8'd1;
        if (!req[sel] || hold_cnt == HOLD_LAST) begin
          state   <= GAP;
          en_n    <= 1'b1;
          grant_n <= 4'b1111;
          ptr     <= sel + 2'd1;
          gap_cnt <= 4'd0;
          timeout <= req[sel];
        end
      end else if (state == GAP) begin
        if (gap_cnt == GAP_LAST) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else gap_cnt <= gap_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_demux_rr_arbiter.sv
// tb_demux_rr_arbiter: directed scenarios plus random traffic against a behavioural arbiter model
module tb_demux_rr_arbiter;
  localparam int MH [4] = '{8, 2, 4, 3};
  localparam int GC [4] = '{1, 1, 1, 3};
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req [4];
  logic [1:0] sel [4];
  logic       en_n [4];
  logic [3:0] grant_n [4];
  logic       busy [4];
  logic       timeout [4];
  int n_vec = 0;
  int n_err = 0;
  int m_owner [4];
  int m_held [4];
  int m_dead [4];
  int m_ptr [4];
  int m_last [4];
  bit m_to [4];
  always #5 clk = ~clk;
  genvar g;
  for (g = 0; g < 4; g++) begin : gi
    demux_rr_arbiter #(.MAX_HOLD(MH[g]), .GAP_CYC(GC[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req[g]), .sel(sel[g]), .en_n(en_n[g]),
      .grant_n(grant_n[g]), .busy(busy[g]), .timeout(timeout[g])
    );
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    for (int i = 0; i < 4; i++) begin
      req[i] = 4'b0000;
      m_owner[i] = -1; m_held[i] = 0; m_dead[i] = 0; m_ptr[i] = 0; m_last[i] = 0; m_to[i] = 0;
    end
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask
  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  // owner view: who holds the decoder, for how long, and how many dead cycles remain
  task automatic model_step(int i, logic [3:0] r);
    m_to[i] = 0;
    if (m_owner[i] >= 0) begin
      if (!r[m_owner[i]] || m_held[i] == MH[i]) begin
        m_to[i] = r[m_owner[i]];
        m_ptr[i] = (m_owner[i] + 1) % 4;
        m_owner[i] = -1;
        m_dead[i] = GC[i];
      end else m_held[i]++;
    end else begin
      if (m_dead[i] > 0) m_dead[i]--;
      if (m_dead[i] == 0 && r != 4'b0000) begin
        m_owner[i] = pick(r, m_ptr[i]);
        m_last[i] = m_owner[i];
        m_held[i] = 1;
      end
    end
  endtask
  task automatic test_reset;
    do_reset();
    req[0] = 4'b0001;
    tick();
    n_vec++; if (grant_n[0] !== 4'b1110) begin n_err++; $display("FAIL rst_pre_grant got %b want 1110", grant_n[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (sel[0] !== 2'b00) begin n_err++; $display("FAIL rst_sel got %b want 00", sel[0]); end
    n_vec++; if (en_n[0] !== 1'b1) begin n_err++; $display("FAIL rst_en_n got %b want 1", en_n[0]); end
    n_vec++; if (grant_n[0] !== 4'b1111) begin n_err++; $display("FAIL rst_grant_n got %b want 1111", grant_n[0]); end
    n_vec++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy[0]); end
    n_vec++; if (timeout[0] !== 1'b0) begin n_err++; $display("FAIL rst_timeout got %b want 0", timeout[0]); end
    #1 rst_n = 1'b1;
    req[0] = 4'b0001;
    tick();
    n_vec++; if (grant_n[0] !== 4'b1110) begin n_err++; $display("FAIL rst_regrant got %b want 1110", grant_n[0]); end
  endtask
  task automatic test_single;
    do_reset();
    req[0] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (sel[0] !== 2'b01 || grant_n[0] !== 4'b1101) begin n_err++; $display("FAIL single_grant c%0d got sel=%b g=%b want 01/1101", k, sel[0], grant_n[0]); end
      n_vec++; if (timeout[0] !== 1'b0) begin n_err++; $display("FAIL single_to c%0d got %b want 0", k, timeout[0]); end
    end
    req[0] = 4'b0000;
    tick();
    n_vec++; if (grant_n[0] !== 4'b1111 || en_n[0] !== 1'b1 || busy[0] !== 1'b1 || timeout[0] !== 1'b0) begin n_err++; $display("FAIL single_gap got g=%b en=%b b=%b to=%b want 1111/1/1/0", grant_n[0], en_n[0], busy[0], timeout[0]); end
    n_vec++; if (sel[0] !== 2'b01) begin n_err++; $display("FAIL single_gap_sel got %b want 01", sel[0]); end
    tick();
    n_vec++; if (busy[0] !== 1'b0 || grant_n[0] !== 4'b1111 || timeout[0] !== 1'b0) begin n_err++; $display("FAIL single_idle got b=%b g=%b to=%b want 0/1111/0", busy[0], grant_n[0], timeout[0]); end
  endtask
  task automatic test_rotation;
    logic [3:0] exp_g;
    do_reset();
    req[1] = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      exp_g = ~(4'b0001 << (o % 4));
      for (int c = 0; c < 2; c++) begin
        tick();
        n_vec++; if (grant_n[1] !== exp_g || timeout[1] !== 1'b0) begin n_err++; $display("FAIL rot_grant o%0d c%0d got g=%b to=%b want %b/0", o, c, grant_n[1], timeout[1], exp_g); end
      end
      tick();
      n_vec++; if (grant_n[1] !== 4'b1111 || timeout[1] !== 1'b1 || busy[1] !== 1'b1) begin n_err++; $display("FAIL rot_gap o%0d got g=%b to=%b b=%b want 1111/1/1", o, grant_n[1], timeout[1], busy[1]); end
    end
  endtask
  task automatic test_wrap_skip;
    do_reset();
    req[0] = 4'b0100;
    tick();
    n_vec++; if (sel[0] !== 2'b10 || grant_n[0] !== 4'b1011) begin n_err++; $display("FAIL wrap_first got sel=%b g=%b want 10/1011", sel[0], grant_n[0]); end
    req[0] = 4'b0001;
    tick();
    n_vec++; if (grant_n[0] !== 4'b1111) begin n_err++; $display("FAIL wrap_gap got %b want 1111", grant_n[0]); end
    req[0] = 4'b0101;
    tick();
    n_vec++; if (sel[0] !== 2'b00 || grant_n[0] !== 4'b1110) begin n_err++; $display("FAIL wrap_to0 got sel=%b g=%b want 00/1110", sel[0], grant_n[0]); end
    req[0] = 4'b0100;
    tick();
    tick();
    n_vec++; if (sel[0] !== 2'b10 || grant_n[0] !== 4'b1011) begin n_err++; $display("FAIL wrap_next2 got sel=%b g=%b want 10/1011", sel[0], grant_n[0]); end
  endtask
  task automatic test_simultaneous;
    do_reset();
    req[2] = 4'b0001;
    repeat (4) tick();
    req[2] = 4'b0000;
    tick();
    n_vec++; if (timeout[2] !== 1'b0 || en_n[2] !== 1'b1) begin n_err++; $display("FAIL simul_to got to=%b en=%b want 0/1", timeout[2], en_n[2]); end
    req[3] = 4'b0010;
    tick();
    req[3] = 4'b0000;
    tick();
    n_vec++; if (grant_n[3] !== 4'b1111) begin n_err++; $display("FAIL gap3_rel got %b want 1111", grant_n[3]); end
    req[3] = 4'b1000;
    for (int c = 1; c < 3; c++) begin
      tick();
      n_vec++; if (en_n[3] !== 1'b1 || busy[3] !== 1'b1) begin n_err++; $display("FAIL gap3_dead c%0d got en=%b b=%b want 1/1", c, en_n[3], busy[3]); end
    end
    tick();
    n_vec++; if (sel[3] !== 2'b11 || grant_n[3] !== 4'b0111) begin n_err++; $display("FAIL gap3_grant got sel=%b g=%b want 11/0111", sel[3], grant_n[3]); end
  endtask
  task automatic test_lone_timeout;
    do_reset();
    req[2] = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++; if (grant_n[2] !== 4'b1011 || timeout[2] !== 1'b0) begin n_err++; $display("FAIL lone_grant c%0d got g=%b to=%b want 1011/0", c, grant_n[2], timeout[2]); end
    end
    tick();
    n_vec++; if (grant_n[2] !== 4'b1111 || timeout[2] !== 1'b1) begin n_err++; $display("FAIL lone_gap got g=%b to=%b want 1111/1", grant_n[2], timeout[2]); end
    tick();
    n_vec++; if (grant_n[2] !== 4'b1011 || timeout[2] !== 1'b0) begin n_err++; $display("FAIL lone_regrant got g=%b to=%b want 1011/0", grant_n[2], timeout[2]); end
  endtask
  task automatic test_random;
    logic [3:0] exp_g;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) < 3) req[i] = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      @(posedge clk);
      for (int i = 0; i < 4; i++) model_step(i, req[i]);
      #1;
      for (int i = 0; i < 4; i++) begin
        exp_g = (m_owner[i] < 0) ? 4'b1111 : ~(4'b0001 << m_owner[i]);
        n_vec++; if (grant_n[i] !== exp_g) begin n_err++; $display("FAIL rnd_grant_n i%0d c%0d got %b want %b", i, c, grant_n[i], exp_g); end
        n_vec++; if (en_n[i] !== (m_owner[i] < 0)) begin n_err++; $display("FAIL rnd_en_n i%0d c%0d got %b want %b", i, c, en_n[i], m_owner[i] < 0); end
        n_vec++; if (sel[i] !== 2'(m_last[i])) begin n_err++; $display("FAIL rnd_sel i%0d c%0d got %0d want %0d", i, c, sel[i], m_last[i]); end
        n_vec++; if (busy[i] !== (m_owner[i] >= 0 || m_dead[i] > 0)) begin n_err++; $display("FAIL rnd_busy i%0d c%0d got %b", i, c, busy[i]); end
        n_vec++; if (timeout[i] !== m_to[i]) begin n_err++; $display("FAIL rnd_timeout i%0d c%0d got %b want %b", i, c, timeout[i], m_to[i]); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap_skip();
    test_simultaneous();
    test_lone_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/demux_rr_arbiter.md
# demux_rr_arbiter

Round-robin arbiter that shares one dual-channel 2-to-4 active-low demux/decoder between four requesters. It drives the decoder's select lines and active-low enable, and mirrors the decoded result as active-low one-hot grants. The block enforces break-before-make between owners, with a programmable dead gap, and a maximum-hold timeout. It sits between the requesting logic and the demux in the binary code-converter datapath.

## Interface
- MAX_HOLD, 8, maximum consecutive GRANT cycles per owner; legal range 1..255.
- GAP_CYC, 1, inactive cycles forced between two grants; legal range 1..15.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester, active-high, level-held while the resource is wanted.
- sel  output  2  decoder select code for the current or last owner.
- en_n  output  1  active-low decoder enable; 0 only in GRANT.
- grant_n  output  4  active-low one-hot grant; 4'b1111 when no owner.
- busy  output  1  1 while in GRANT or GAP.
- timeout  output  1  one-cycle pulse on a forced release.

## Operation
- All outputs are registered.
- Reset values (asynchronous, applied immediately, including mid-grant):
  - state=IDLE, sel=2'b00, en_n=1, grant_n=4'b1111, busy=0, timeout=0.
  - Round-robin pointer ptr=0; hold and gap counters at 0.
- States:
  - **IDLE:** outputs inactive. At each edge, if req≠0, pick the winner and go to GRANT; otherwise stay.
- Winner selection: first set bit of req scanning ptr, ptr+1, … modulo 4 (3 wraps to 0).
- Entering GRANT sets all of the following:
  - sel=winner, en_n=0, grant_n[winner]=0 (other bits 1), busy=1, hold counter=0.
  - grant_n always equals the active-low 2-to-4 decode of sel when en_n=0.
- **GRANT:** the hold counter increments each cycle. At each edge:
  - If req[winner]=0: normal release.
  - Else if hold counter = MAX_HOLD-1: forced release, and timeout=1 for the next cycle.
  - Else: stay.
  - req changes on non-owner bits have no effect while in GRANT.
- Either release does the following:
  - en_n=1, grant_n=4'b1111, busy=1, and sel keeps the winner.
  - ptr=winner+1 mod 4, gap counter=0, go to GAP.
- If req[winner] drops on the same edge the hold limit is reached, the release is normal and timeout stays 0.
- **GAP:** outputs inactive, and the gap counter increments. At the edge where the gap counter = GAP_CYC-1:
  - If req≠0: arbitrate from the updated ptr and go to GRANT.
  - Otherwise: go to IDLE with busy=0.
- A timed-out owner that still holds req is eligible again only in normal rotation order. It wins immediately only if no other request is pending.
- Counter widths: hold uses 8 bits, gap uses 4 bits; neither counter ever wraps.

## Timing
- Request-to-grant latency from IDLE: req high before edge N gives grant visible after edge N (1 cycle).
- Release latency: req[owner] low sampled at edge K gives en_n=1 and grant_n=4'b1111 after edge K.
- Dead time: exactly GAP_CYC cycles of en_n=1 between consecutive grants.
  - If requests are pending, the next grant appears after edge K+GAP_CYC.
- Grant duration: minimum 1 cycle, maximum MAX_HOLD cycles.
- timeout is high for exactly the first GAP cycle after a forced release.
- Never two grant_n bits low at once, and no cycle with en_n=0 and grant_n=4'b1111.

## Test plan
- **Reset values:** assert rst_n=0 mid-GRANT, between edges → sel=00, en_n=1, grant_n=1111, busy=0, timeout=0 immediately. After release, req=0001 → grant_n=1110 one cycle later.
- **Single requester:** MAX_HOLD=8, GAP_CYC=1; req=0010 held 3 cycles then dropped.
  - → sel=01, grant_n=1101 for 3 cycles, then 1 cycle of 1111 in GAP, then IDLE with busy=0 and timeout never 1.
- **Rotation:** req=1111 held permanently, MAX_HOLD=2.
  - → owners in order 0,1,2,3,0; each grant lasts 2 cycles and each ends with a timeout pulse.
  - Exactly 1 dead cycle between grants.
- **Wrap and skip:** ptr=3 after owner 2 releases, req=0101 → requester 0 is granted (sel=00, grant_n=1110). Requester 2 is granted next.
- **Simultaneous events:** req[owner] drops on the same edge the hold limit is reached → timeout stays 0.
  - With GAP_CYC=3 and a new req arriving during GAP, the grant appears exactly 3 cycles after release.
- **Lone timed-out owner:** MAX_HOLD=4, req=0100 held → grant 4 cycles, timeout pulse, 1 gap cycle, then requester 2 is re-granted.
